// File: rtl/aftab_csr_access_controller.sv
// Initiator side of the CSR register-bank port: sequences Zicsr read -> modify -> write.
// Define AFTAB_CSR_MIRROR_EN to redirect ustatus/uie/uip to their machine copies under a bit mask.
module aftab_csr_access_controller #(
    parameter int              len          = 32,
    parameter logic [len-1:0]  USTATUS_MASK = 32'h00000011,
    parameter logic [len-1:0]  UIE_MASK     = 32'h00000111,
    parameter logic [len-1:0]  UIP_MASK     = 32'h00000111
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           start_i,
    input  logic [2:0]     funct3_i,
    input  logic [11:0]    csrAddr_i,
    input  logic [len-1:0] rs1Data_i,
    input  logic [4:0]     srcField_i,
    input  logic [len-1:0] outRegBank_i,
    input  logic           mirrorUstatus_i,
    input  logic           mirrorUie_i,
    input  logic           mirrorUip_i,
    input  logic           mirror_i,
    output logic [11:0]    addressRegBank_o,
    output logic [len-1:0] inputRegBank_o,
    output logic           writeRegBank_o,
    output logic           busy_o,
    output logic           done_o,
    output logic [len-1:0] rdData_o,
    output logic           illegal_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        READ  = 2'b01,
        WRITE = 2'b10,
        DONE  = 2'b11
    } state_e;

    state_e         state_q, state_d;
    logic [1:0]     funct3_q;
    logic [11:0]    csrAddr_q;
    logic [len-1:0] operand_q;
    logic           srcZero_q;
    logic [len-1:0] old_q;
    logic [len-1:0] rdData_q;
    logic [len-1:0] inputRegBank_q;
    logic           illegal_q;

    logic [11:0]    effAddr;
    logic [len-1:0] modified;
    logic [len-1:0] newVal;
    logic [len-1:0] rdValue;
    logic           legal;
    logic           wrEn;
    logic           illegalNow;

`ifdef AFTAB_CSR_MIRROR_EN
    logic           mirror_q, mirrorUstatus_q, mirrorUie_q, mirrorUip_q;
    logic [len-1:0] mask;

    // Mirror decode comes from the bank while it still sees csrAddr in IDLE.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mirror_q        <= 1'b0;
            mirrorUstatus_q <= 1'b0;
            mirrorUie_q     <= 1'b0;
            mirrorUip_q     <= 1'b0;
        end else if (state_q == IDLE && start_i) begin
            mirror_q        <= mirror_i;
            mirrorUstatus_q <= mirrorUstatus_i;
            mirrorUie_q     <= mirrorUie_i;
            mirrorUip_q     <= mirrorUip_i;
        end
    end

    always_comb begin
        mask = '1;
        if (mirrorUstatus_q)
            mask = USTATUS_MASK;
        else if (mirrorUie_q)
            mask = UIE_MASK;
        else if (mirrorUip_q)
            mask = UIP_MASK;
        effAddr = mirror_q ? (csrAddr_q | 12'h300) : csrAddr_q;
    end
`else
    logic unusedMirror;
    assign unusedMirror = ^{mirror_i, mirrorUstatus_i, mirrorUie_i, mirrorUip_i,
                            USTATUS_MASK, UIE_MASK, UIP_MASK};
    assign effAddr      = csrAddr_q;
`endif

    always_comb begin
        case (funct3_q)
            2'b10:   modified = old_q | operand_q;
            2'b11:   modified = old_q & ~operand_q;
            default: modified = operand_q;
        endcase
        newVal  = modified;
        rdValue = old_q;
`ifdef AFTAB_CSR_MIRROR_EN
        if (mirror_q) begin
            newVal  = (old_q & ~mask) | (modified & mask);
            rdValue = old_q & mask;
        end
`endif
        legal      = (funct3_q != 2'b00);
        // RS/RC with a zero source never write, so they may read read-only CSRs.
        wrEn       = legal && !(funct3_q[1] && srcZero_q);
        illegalNow = !legal || (csrAddr_q[11:10] == 2'b11 && wrEn);
    end

    always_comb begin
        state_d          = state_q;
        busy_o           = (state_q != IDLE);
        done_o           = (state_q == DONE);
        illegal_o        = (state_q == DONE) && illegal_q;
        writeRegBank_o   = 1'b0;
        inputRegBank_o   = inputRegBank_q;
        addressRegBank_o = effAddr;
        case (state_q)
            IDLE: begin
                addressRegBank_o = csrAddr_i;
                if (start_i)
                    state_d = READ;
            end
            READ:  state_d = WRITE;
            WRITE: begin
                writeRegBank_o = wrEn && !illegalNow;
                inputRegBank_o = newVal;
                state_d        = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= IDLE;
            funct3_q       <= 2'b00;
            csrAddr_q      <= 12'h000;
            operand_q      <= '0;
            srcZero_q      <= 1'b0;
            old_q          <= '0;
            rdData_q       <= '0;
            inputRegBank_q <= '0;
            illegal_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        funct3_q  <= funct3_i[1:0];
                        csrAddr_q <= csrAddr_i;
                        operand_q <= funct3_i[2] ? {{(len-5){1'b0}}, srcField_i} : rs1Data_i;
                        srcZero_q <= (srcField_i == 5'd0);
                    end
                end
                READ: old_q <= outRegBank_i;
                WRITE: begin
                    inputRegBank_q <= newVal;
                    rdData_q       <= rdValue;
                    illegal_q      <= illegalNow;
                end
                default: ;
            endcase
        end
    end

    assign rdData_o = rdData_q;

endmodule

// File: tb/tb_aftab_csr_access_controller.sv
// Scoreboard bench for aftab_csr_access_controller: randomized Zicsr ops against a CSR-level model.
// Honours AFTAB_CSR_MIRROR_EN the same way the design does.
module tb_aftab_csr_access_controller;

    logic        clk;
    logic        rstN;
    logic        start;
    logic [2:0]  funct3;
    logic [11:0] csrAddr;
    logic [31:0] rs1Data;
    logic [4:0]  srcField;
    logic [31:0] outRegBank;
    logic        mirrorUstatus, mirrorUie, mirrorUip, mirror;
    logic [11:0] addressRegBank;
    logic [31:0] inputRegBank;
    logic        writeRegBank, busy, done, illegal;
    logic [31:0] rdData;

    typedef struct {
        logic [31:0] rd;
        logic        ill;
        logic        doWrite;
        logic [11:0] wAddr;
        logic [31:0] wData;
        int          acceptCycle;
    } exp_t;

    exp_t        expQ[$];
    logic [31:0] bankMem [0:4095];
    logic [31:0] refMem  [0:4095];
    int          compared = 0;
    int          mismatched = 0;
    int          cycleCnt = 0;
    int          wrCount = 0;
    logic [11:0] wrAddr;
    logic [31:0] wrData;
    logic [11:0] addrTable [10] = '{12'h340, 12'h304, 12'h300, 12'h305, 12'h000,
                                    12'h004, 12'h044, 12'hC00, 12'hF11, 12'h341};

    aftab_csr_access_controller dut (
        .clk_i(clk), .rst_ni(rstN), .start_i(start), .funct3_i(funct3),
        .csrAddr_i(csrAddr), .rs1Data_i(rs1Data), .srcField_i(srcField),
        .outRegBank_i(outRegBank), .mirrorUstatus_i(mirrorUstatus), .mirrorUie_i(mirrorUie),
        .mirrorUip_i(mirrorUip), .mirror_i(mirror), .addressRegBank_o(addressRegBank),
        .inputRegBank_o(inputRegBank), .writeRegBank_o(writeRegBank), .busy_o(busy),
        .done_o(done), .rdData_o(rdData), .illegal_o(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    // Register bank: combinational read and address decode, write on the clock.
    assign outRegBank    = bankMem[addressRegBank];
    assign mirrorUstatus = (addressRegBank == 12'h000);
    assign mirrorUie     = (addressRegBank == 12'h004);
    assign mirrorUip     = (addressRegBank == 12'h044);
    assign mirror        = mirrorUstatus | mirrorUie | mirrorUip;

    always @(posedge clk) begin
        if (writeRegBank)
            bankMem[addressRegBank] = inputRegBank;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // CSR-level behaviour: what the instruction must do to the architectural register file.
    function automatic exp_t model(input logic [2:0] f3, input logic [11:0] addr,
                                   input logic [31:0] rs1, input logic [4:0] src);
        exp_t        e;
        logic [31:0] op, old, mask, nv;
        logic [11:0] eff;
        logic        legal, wrEn;
        op   = f3[2] ? {27'd0, src} : rs1;
        eff  = addr;
        mask = 32'hFFFFFFFF;
`ifdef AFTAB_CSR_MIRROR_EN
        if (addr == 12'h000) begin eff = 12'h300; mask = 32'h00000011; end
        if (addr == 12'h004) begin eff = 12'h304; mask = 32'h00000111; end
        if (addr == 12'h044) begin eff = 12'h344; mask = 32'h00000111; end
`endif
        old = refMem[eff];
        case (f3[1:0])
            2'b01:   nv = op;
            2'b10:   nv = old | op;
            2'b11:   nv = old & ~op;
            default: nv = old;
        endcase
        nv        = (old & ~mask) | (nv & mask);
        legal     = (f3[1:0] != 2'b00);
        wrEn      = legal && !((f3 == 3'b010 || f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) && src == 5'd0);
        e.ill     = !legal || (addr >= 12'hC00 && wrEn);
        e.doWrite = wrEn && !e.ill;
        e.wAddr   = eff;
        e.wData   = nv;
        e.rd      = old & mask;
        e.acceptCycle = 0;
        return e;
    endfunction

    // Monitor: records bank writes and checks each completion against the scoreboard.
    always @(negedge clk) begin
        if (rstN) begin
            if (writeRegBank) begin
                wrCount = wrCount + 1;
                wrAddr  = addressRegBank;
                wrData  = inputRegBank;
            end
            if (done) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedDone", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = expQ.pop_front();
                    checkOutput("rdData", rdData, e.rd);
                    checkOutput("illegal", {31'd0, illegal}, {31'd0, e.ill});
                    checkOutput("latency", cycleCnt - e.acceptCycle, 32'd2);
                    checkOutput("writeCount", wrCount, {31'd0, e.doWrite});
                    if (e.doWrite && wrCount == 1) begin
                        checkOutput("writeAddr", {20'd0, wrAddr}, {20'd0, e.wAddr});
                        checkOutput("writeData", wrData, e.wData);
                    end
                    if (e.doWrite)
                        refMem[e.wAddr] = e.wData;
                end
                wrCount = 0;
            end
        end
    end

    task automatic initMem(input logic [11:0] addr, input logic [31:0] val);
        bankMem[addr] = val;
        refMem[addr]  = val;
    endtask

    task automatic waitIdle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (busy)
            checkOutput("idleTimeout", {31'd0, busy}, 32'd0);
    endtask

    task automatic applyStimulus(input logic [2:0] f3, input logic [11:0] addr,
                                 input logic [31:0] rs1, input logic [4:0] src, input int extra);
        exp_t e;
        waitIdle();
        funct3   = f3;
        csrAddr  = addr;
        rs1Data  = rs1;
        srcField = src;
        start    = 1'b1;
        e = model(f3, addr, rs1, src);
        e.acceptCycle = cycleCnt + 1;
        expQ.push_back(e);
        @(posedge clk);
        @(negedge clk);
        checkOutput("busyAfterStart", {31'd0, busy}, 32'd1);
        for (int k = 0; k < extra; k++) begin
            funct3   = 3'($urandom_range(0, 7));
            csrAddr  = addrTable[$urandom_range(0, 9)];
            rs1Data  = $urandom;
            srcField = 5'($urandom_range(0, 31));
            @(posedge clk);
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rstN = 1'b0; start = 1'b0; funct3 = 3'd0; csrAddr = 12'd0; rs1Data = 32'd0; srcField = 5'd0;
        for (int a = 0; a < 4096; a++)
            initMem(12'(a), $urandom);
        repeat (3) @(negedge clk);
        checkOutput("resetBusy", {31'd0, busy}, 32'd0);
        checkOutput("resetDone", {31'd0, done}, 32'd0);
        checkOutput("resetWrite", {31'd0, writeRegBank}, 32'd0);
        checkOutput("resetRdData", rdData, 32'd0);
        checkOutput("resetInput", inputRegBank, 32'd0);
        rstN = 1'b1;

        initMem(12'h340, 32'h12345678);
        applyStimulus(3'b001, 12'h340, 32'hDEADBEEF, 5'd1, 0);
        initMem(12'h304, 32'h00000880);
        applyStimulus(3'b010, 12'h304, $urandom, 5'd0, 1);
        initMem(12'h300, 32'h00001888);
        applyStimulus(3'b111, 12'h300, $urandom, 5'h08, 2);
        applyStimulus(3'b001, 12'h004, 32'hFFFFFFFF, 5'd3, 0);
        applyStimulus(3'b001, 12'hC00, 32'h0000BEEF, 5'd2, 0);
        applyStimulus(3'b100, 12'h340, 32'h0BADF00D, 5'd4, 0);
        applyStimulus(3'b010, 12'hC00, 32'h0000FFFF, 5'd0, 0);

        // Abort an operation in its write cycle.
        waitIdle();
        funct3 = 3'b001; csrAddr = 12'h341; rs1Data = 32'hA5A5A5A5; srcField = 5'd7; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        checkOutput("abortWriteSeen", {31'd0, writeRegBank}, 32'd1);
        #2 rstN = 1'b0;
        #1;
        checkOutput("abortWrite", {31'd0, writeRegBank}, 32'd0);
        checkOutput("abortBusy", {31'd0, busy}, 32'd0);
        checkOutput("abortRdData", rdData, 32'd0);
        checkOutput("abortInput", inputRegBank, 32'd0);
        wrCount = 0;
        repeat (2) @(negedge clk);
        rstN = 1'b1;
        applyStimulus(3'b001, 12'h341, 32'h5A5A5A5A, 5'd7, 0);

        for (int i = 0; i < 150; i++) begin
            logic [4:0] src;
            src = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            applyStimulus(3'($urandom_range(0, 7)), addrTable[$urandom_range(0, 9)],
                          $urandom, src, $urandom_range(0, 2));
        end

        waitIdle();
        repeat (2) @(negedge clk);
        checkOutput("scoreboardEmpty", expQ.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
